alu4: RTL and testbench

- Registered combinational-style arithmetic/logic unit: two WIDTH-bit operands, 3-bit operation select, result plus carry/borrow.
- One-cycle latency, valid-qualified; used as the datapath ALU stage between operand fetch and writeback.
- Synchronous, active-high reset; single clock domain.

---
 rtl/alu4_if.sv | 36 +++
 rtl/alu4.sv | 117 +++++++++++
 tb/tb_alu4.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu4_if.sv
// rtl/alu4_if.sv - operand/result bundle for alu4; Zero/Overflow present only with ALU_FLAGS_EN
interface alu4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_Sel;
  logic             out_valid;
  logic [WIDTH-1:0] ALU_Out;
  logic             Carry_Out;
`ifdef ALU_FLAGS_EN
  logic             Zero;
  logic             Overflow;

  modport master (
    output in_valid, A, B, ALU_Sel,
    input  out_valid, ALU_Out, Carry_Out, Zero, Overflow
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel,
    output out_valid, ALU_Out, Carry_Out, Zero, Overflow
  );
`else
  modport master (
    output in_valid, A, B, ALU_Sel,
    input  out_valid, ALU_Out, Carry_Out
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel,
    output out_valid, ALU_Out, Carry_Out
  );
`endif
endinterface

// File: rtl/alu4.sv
// rtl/alu4.sv - one-cycle registered ALU (ADD/SUB/AND/OR/XOR/NOT/SHL/SHR); optional flags via ALU_FLAGS_EN
module alu4 #(
  parameter int WIDTH = 4
) (
  input logic   clk,
  input logic   rst,
  alu4_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             carry;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;

`ifdef ALU_FLAGS_EN
  logic             ovf;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
`endif

  // Result and carry/borrow for the selected operation, from the current inputs
  always_comb begin
    sum   = {1'b0, bus.A} + {1'b0, bus.B};
    diff  = {1'b0, bus.A} - {1'b0, bus.B};
    res   = '0;
    carry = 1'b0;
    case (bus.ALU_Sel)
      3'b000: begin
        res   = sum[MSB:0];
        carry = sum[WIDTH];
      end
      3'b001: begin
        // The extra top bit of the widened difference is set exactly when A < B
        res   = diff[MSB:0];
        carry = diff[WIDTH];
      end
      3'b010: res = bus.A & bus.B;
      3'b011: res = bus.A | bus.B;
      3'b100: res = bus.A ^ bus.B;
      3'b101: res = ~bus.A;
      3'b110: begin
        res   = {bus.A[MSB-1:0], 1'b0};
        carry = bus.A[MSB];
      end
      3'b111: begin
        res   = {1'b0, bus.A[MSB:1]};
        carry = bus.A[0];
      end
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Signed overflow: ADD with like-signed operands, SUB with unlike-signed operands, when the sign flips
  always_comb begin
    ovf = 1'b0;
    if (bus.ALU_Sel == 3'b000)
      ovf = (bus.A[MSB] == bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
    else if (bus.ALU_Sel == 3'b001)
      ovf = (bus.A[MSB] != bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
  end
`endif

  // Next-state: load a new result when in_valid, otherwise hold; out_valid follows in_valid
  always_comb begin
    valid_d = bus.in_valid;
    out_d   = out_q;
    carry_d = carry_q;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    if (bus.in_valid) begin
      out_d   = res;
      carry_d = carry;
`ifdef ALU_FLAGS_EN
      zero_d  = (res == '0);
      ovf_d   = ovf;
`endif
    end
  end

  // Output registers; reset wins over a same-cycle input
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      carry_q <= carry_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ALU_Out   = out_q;
  assign bus.Carry_Out = carry_q;
`ifdef ALU_FLAGS_EN
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu4.sv
// tb/tb_alu4.sv - randomized and directed bench for alu4 against an arithmetic reference model
module tb_alu4;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu4_if #(.WIDTH(W)) bus();

  alu4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the most recent edge
  int m_valid = 0;
  int m_out   = 0;
  int m_carry = 0;
  int m_zero  = 0;
  int m_ovf   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, return at the following negedge
  task automatic step(input int v, input int a, input int b, input int sel, input int r);
    int s;
    int sr;
    rst          = r[0];
    bus.in_valid = v[0];
    bus.A        = a[W-1:0];
    bus.B        = b[W-1:0];
    bus.ALU_Sel  = sel[2:0];
    @(posedge clk);
    if (r != 0) begin
      m_valid = 0; m_out = 0; m_carry = 0; m_zero = 0; m_ovf = 0;
    end else if (v != 0) begin
      m_valid = 1;
      m_carry = 0;
      m_ovf   = 0;
      case (sel)
        0: begin
          s = a + b; m_out = s % M; m_carry = (s >= M) ? 1 : 0;
          sr = to_signed(a) + to_signed(b);
          m_ovf = (sr >= M / 2 || sr < -(M / 2)) ? 1 : 0;
        end
        1: begin
          s = a - b; m_out = (s + M) % M; m_carry = (a < b) ? 1 : 0;
          sr = to_signed(a) - to_signed(b);
          m_ovf = (sr >= M / 2 || sr < -(M / 2)) ? 1 : 0;
        end
        2: m_out = a & b;
        3: m_out = a | b;
        4: m_out = a ^ b;
        5: m_out = M - 1 - a;
        6: begin m_out = (a * 2) % M; m_carry = a / (M / 2); end
        default: begin m_out = a / 2; m_carry = a % 2; end
      endcase
      m_zero = (m_out == 0) ? 1 : 0;
    end else begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), m_valid);
    chk("ALU_Out",   int'(bus.ALU_Out),   m_out);
    chk("Carry_Out", int'(bus.Carry_Out), m_carry);
`ifdef ALU_FLAGS_EN
    chk("Zero",      int'(bus.Zero),      m_zero);
    chk("Overflow",  int'(bus.Overflow),  m_ovf);
`endif
  end

  task automatic lit(input string name, input int vld, input int out, input int carry);
    chk({name, ".valid"}, int'(bus.out_valid), vld);
    chk({name, ".out"},   int'(bus.ALU_Out),   out);
    chk({name, ".carry"}, int'(bus.Carry_Out), carry);
  endtask

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_Sel = '0;

    // Reset with a valid input pending: must be dropped
    step(1, 15, 15, 0, 1); lit("rst0", 0, 0, 0);
    step(1, 15, 15, 0, 1); lit("rst1", 0, 0, 0);
    step(0, 0, 0, 0, 0);   lit("idle", 0, 0, 0);

    // Add / sub
    step(1, 4'b0011, 4'b0001, 0, 0); lit("add", 1, 4'b0100, 0);
    step(1, 4'b1111, 4'b0001, 0, 0); lit("add_wrap", 1, 4'b0000, 1);
`ifdef ALU_FLAGS_EN
    chk("add_wrap.zero", int'(bus.Zero), 1);
`endif
    step(1, 4'b0110, 4'b0010, 1, 0); lit("sub", 1, 4'b0100, 0);
    step(1, 4'b0001, 4'b0010, 1, 0); lit("sub_borrow", 1, 4'b1111, 1);

    // Logic
    step(1, 4'b1100, 4'b1010, 2, 0); lit("and", 1, 4'b1000, 0);
    step(1, 4'b1100, 4'b1010, 3, 0); lit("or",  1, 4'b1110, 0);
    step(1, 4'b1100, 4'b1010, 4, 0); lit("xor", 1, 4'b0110, 0);
    step(1, 4'b1100, 4'b1010, 5, 0); lit("not", 1, 4'b0011, 0);

    // Shifts
    step(1, 4'b1001, 4'b0000, 6, 0); lit("shl", 1, 4'b0010, 1);
    step(1, 4'b1001, 4'b0000, 7, 0); lit("shr", 1, 4'b0100, 1);

    // Back-to-back then idle: result holds with out_valid low
    step(1, 2, 3, 0, 0); lit("b2b0", 1, 5, 0);
    step(1, 9, 4, 1, 0); lit("b2b1", 1, 5, 0);
    step(1, 6, 3, 4, 0); lit("b2b2", 1, 5, 0);
    step(0, 1, 1, 0, 0); lit("hold0", 0, 5, 0);
    step(0, 7, 7, 3, 0); lit("hold1", 0, 5, 0);

    // Reset mid-stream
    step(1, 15, 1, 0, 0); lit("pre_rst", 1, 0, 1);
    step(1, 3, 3, 0, 1);  lit("mid_rst", 0, 0, 0);

`ifdef ALU_FLAGS_EN
    step(1, 4'b0111, 4'b0001, 0, 0); lit("ovf_add", 1, 4'b1000, 0);
    chk("ovf_add.ovf", int'(bus.Overflow), 1);
    step(1, 4'b1000, 4'b0001, 1, 0); lit("ovf_sub", 1, 4'b0111, 0);
    chk("ovf_sub.ovf", int'(bus.Overflow), 1);
    step(1, 4'b0101, 4'b0101, 4, 0); lit("zero_xor", 1, 4'b0000, 0);
    chk("zero_xor.zero", int'(bus.Zero), 1);
`endif

    // Randomized traffic with occasional idle cycles and resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 49) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
